// File: rtl/button_pkg.sv
// Shared definitions for the debounced button counter.
//   MODE_WRAP / MODE_SATURATE : counter limit behaviour selectors
//   repeat_state_t            : per-button auto-repeat FSM encoding
//   clog2()                   : bit width needed to hold values 0..value-1 (minimum 1)
package button_pkg;

    localparam int MODE_WRAP     = 0;
    localparam int MODE_SATURATE = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } repeat_state_t;

    // Width of a timer that counts 0..value-1; never returns less than 1 bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Conditions one raw active-low button: inversion, 2-FF synchroniser,
// debounce counter and rising-edge detect on the accepted level.
//   clock, reset : system clock, synchronous active-high reset
//   btn_n        : raw active-low button, asynchronous to clock
//   pressed      : debounced level, 1 while the button is accepted as pressed
//   press_pulse  : one-cycle pulse on each accepted released-to-pressed change
module button_debouncer
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n,
    output logic pressed,
    output logic press_pulse
);

    localparam int               CNT_W    = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             stable_reg;
    logic             stable_prev_reg;
    logic             pulse_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg       <= 1'b0;
            sync2_reg       <= 1'b0;
            stable_reg      <= 1'b0;
            stable_prev_reg <= 1'b0;
            pulse_reg       <= 1'b0;
            cnt_reg         <= '0;
        end else begin
            sync1_reg <= ~btn_n;
            sync2_reg <= sync1_reg;
            // Any sample that agrees with the accepted level restarts the
            // qualification, so only an unbroken run of DEBOUNCE_CYCLES
            // disagreeing samples flips the accepted level.
            if (sync2_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                stable_reg <= sync2_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            stable_prev_reg <= stable_reg;
            pulse_reg       <= stable_reg & ~stable_prev_reg;
        end
    end

    assign pressed     = stable_reg;
    assign press_pulse = pulse_reg;

endmodule

// File: rtl/button_counter_debounced.sv
// Up/down/clear button counter running from the system clock. Each button is
// debounced into a single-cycle event; up and down optionally auto-repeat.
//   clock, reset                      : system clock, synchronous active-high reset
//   btn_up_n, btn_down_n, btn_clear_n : raw active-low buttons (asynchronous)
//   count                             : current WIDTH-bit count (drives the LEDs)
//   limit_hit                         : one-cycle pulse when a step hits a limit
//   held                              : debounced up OR down, registered
module button_counter_debounced
    import button_pkg::*;
#(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int SATURATE        = MODE_WRAP,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 24000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_up_n,
    input  logic             btn_down_n,
    input  logic             btn_clear_n,
    output logic [WIDTH-1:0] count,
    output logic             limit_hit,
    output logic             held
);

    localparam int TMR_W = clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

    // Button index: 0 = up, 1 = down, 2 = clear.
    logic [2:0] btn_n_vec;
    logic [2:0] pressed_vec;
    logic [2:0] pulse_vec;
    logic [1:0] step_vec;

    assign btn_n_vec = {btn_clear_n, btn_down_n, btn_up_n};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            button_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debouncer (
                .clock      (clock),
                .reset      (reset),
                .btn_n      (btn_n_vec[gi]),
                .pressed    (pressed_vec[gi]),
                .press_pulse(pulse_vec[gi])
            );
        end

        // Only up and down get auto-repeat; clear is a single event per press.
        for (gi = 0; gi < 2; gi++) begin : g_step
            if (REPEAT_DELAY > 0) begin : g_repeat
                localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
                localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

                repeat_state_t    state_reg;
                repeat_state_t    state_next;
                logic [TMR_W-1:0] timer_reg;
                logic [TMR_W-1:0] timer_next;
                logic             repeat_step;

                always_ff @(posedge clock) begin
                    if (reset) begin
                        state_reg <= IDLE;
                        timer_reg <= '0;
                    end else begin
                        state_reg <= state_next;
                        timer_reg <= timer_next;
                    end
                end

                always_comb begin
                    state_next = state_reg;
                    timer_next = '0;
                    if (!pressed_vec[gi]) begin
                        state_next = IDLE;
                    end else begin
                        case (state_reg)
                            IDLE: begin
                                if (pulse_vec[gi]) begin
                                    state_next = DELAY;
                                end
                            end
                            DELAY: begin
                                if (timer_reg == DELAY_LAST) begin
                                    state_next = REPEAT;
                                end else begin
                                    timer_next = timer_reg + 1'b1;
                                end
                            end
                            REPEAT: begin
                                // Timer wraps to 0 on the step cycle.
                                if (timer_reg != PERIOD_LAST) begin
                                    timer_next = timer_reg + 1'b1;
                                end
                            end
                            default: state_next = IDLE;
                        endcase
                    end
                end

                // Step fires on the last cycle of the delay (entry into REPEAT)
                // and on the last cycle of every repeat period.
                always_comb begin
                    repeat_step = 1'b0;
                    if (pressed_vec[gi]) begin
                        case (state_reg)
                            DELAY:   repeat_step = (timer_reg == DELAY_LAST);
                            REPEAT:  repeat_step = (timer_reg == PERIOD_LAST);
                            default: repeat_step = 1'b0;
                        endcase
                    end
                end

                assign step_vec[gi] = pulse_vec[gi] | repeat_step;
            end else begin : g_single
                assign step_vec[gi] = pulse_vec[gi];
            end
        end
    endgenerate

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             limit_hit_reg;
    logic             limit_hit_next;
    logic             held_reg;
    logic             at_max;
    logic             at_min;

    assign at_max = (count_reg == {WIDTH{1'b1}});
    assign at_min = (count_reg == '0);

    always_comb begin
        count_next     = count_reg;
        limit_hit_next = 1'b0;
        if (pulse_vec[2]) begin
            count_next = '0;
        end else if (step_vec[0] && !step_vec[1]) begin
            limit_hit_next = at_max;
            if (!(at_max && SATURATE == MODE_SATURATE)) begin
                count_next = count_reg + 1'b1;
            end
        end else if (step_vec[1] && !step_vec[0]) begin
            limit_hit_next = at_min;
            if (!(at_min && SATURATE == MODE_SATURATE)) begin
                count_next = count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg     <= '0;
            limit_hit_reg <= 1'b0;
            held_reg      <= 1'b0;
        end else begin
            count_reg     <= count_next;
            limit_hit_reg <= limit_hit_next;
            held_reg      <= pressed_vec[0] | pressed_vec[1];
        end
    end

    assign count     = count_reg;
    assign limit_hit = limit_hit_reg;
    assign held      = held_reg;

endmodule

// File: tb/tb_button_counter_debounced.sv
// Bench for button_counter_debounced. Two instances share the buttons:
// dut_a wraps and auto-repeats (delay 8, period 3), dut_b saturates with no
// repeat. A reference model derived from the timing rules (debounce window,
// press latency, repeat schedule, count priority) is checked every cycle.
module tb_button_counter_debounced;

    localparam int W    = 3;
    localparam int D    = 4;
    localparam int RD_A = 8;
    localparam int RP_A = 3;
    localparam int MAXC = (1 << W) - 1;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         btn_up_n = 1'b1;
    logic         btn_down_n = 1'b1;
    logic         btn_clear_n = 1'b1;
    logic [W-1:0] count_a, count_b;
    logic         limit_a, limit_b, held_a, held_b;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    button_counter_debounced #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .SATURATE(0),
        .REPEAT_DELAY(RD_A), .REPEAT_PERIOD(RP_A)
    ) dut_a (
        .clock(clock), .reset(reset),
        .btn_up_n(btn_up_n), .btn_down_n(btn_down_n), .btn_clear_n(btn_clear_n),
        .count(count_a), .limit_hit(limit_a), .held(held_a)
    );

    button_counter_debounced #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .SATURATE(1),
        .REPEAT_DELAY(0), .REPEAT_PERIOD(RP_A)
    ) dut_b (
        .clock(clock), .reset(reset),
        .btn_up_n(btn_up_n), .btn_down_n(btn_down_n), .btn_clear_n(btn_clear_n),
        .count(count_b), .limit_hit(limit_b), .held(held_b)
    );

    // ---------------- reference model ----------------
    bit win[3][D+2];     // raw pressed samples, [0] = this edge
    bit st_now[3];       // accepted level after this edge
    bit st_1[3];         // ... after the previous edge
    bit st_2[3];         // ... two edges ago
    bit pulse_m[3];      // press events visible after this edge
    bit in_press[2];
    int press_edge[2];
    bit step_m[2][2];    // [config][button] step events visible after this edge
    int m_count[2];
    bit m_limit[2];
    bit m_held;
    int edge_n;

    function automatic bit repeat_due(int c, int d);
        if (c != 0) return 1'b0;
        if (d == RD_A) return 1'b1;
        return (d > RD_A) && (((d - RD_A) % RP_A) == 0);
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < D + 2; k++) win[b][k] = 1'b0;
            st_now[b] = 1'b0; st_1[b] = 1'b0; st_2[b] = 1'b0; pulse_m[b] = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            m_count[c] = 0; m_limit[c] = 1'b0;
            in_press[c] = 1'b0; press_edge[c] = 0;
            step_m[c][0] = 1'b0; step_m[c][1] = 1'b0;
        end
        m_held = 1'b0;
        edge_n = 0;
    endtask

    task automatic apply_count(int c, bit up, bit down, bit clr);
        m_limit[c] = 1'b0;
        if (clr) begin
            m_count[c] = 0;
        end else if (up && !down) begin
            if (m_count[c] == MAXC) begin
                m_limit[c] = 1'b1;
                if (c == 0) m_count[c] = 0;
            end else begin
                m_count[c] = m_count[c] + 1;
            end
        end else if (down && !up) begin
            if (m_count[c] == 0) begin
                m_limit[c] = 1'b1;
                if (c == 0) m_count[c] = MAXC;
            end else begin
                m_count[c] = m_count[c] - 1;
            end
        end
    endtask

    task automatic model_edge();
        bit raw[3];
        bit flip;
        raw[0] = ~btn_up_n; raw[1] = ~btn_down_n; raw[2] = ~btn_clear_n;
        // count changes on the edge after its event became visible
        for (int c = 0; c < 2; c++) apply_count(c, step_m[c][0], step_m[c][1], pulse_m[2]);
        edge_n = edge_n + 1;
        for (int b = 0; b < 3; b++) begin
            st_2[b] = st_1[b];
            st_1[b] = st_now[b];
            for (int k = D + 1; k > 0; k--) win[b][k] = win[b][k-1];
            win[b][0] = raw[b];
            // accept a new level once D consecutive synchronised samples
            // (raw samples from 2 edges earlier) all disagree with it
            flip = 1'b1;
            for (int k = 2; k < D + 2; k++) if (win[b][k] == st_now[b]) flip = 1'b0;
            if (flip) st_now[b] = ~st_now[b];
            pulse_m[b] = st_1[b] & ~st_2[b];
        end
        m_held = st_1[0] | st_1[1];
        for (int b = 0; b < 2; b++) begin
            if (pulse_m[b]) begin
                in_press[b] = 1'b1;
                press_edge[b] = edge_n;
            end
            if (!st_now[b]) in_press[b] = 1'b0;
            for (int c = 0; c < 2; c++)
                step_m[c][b] = pulse_m[b] ||
                               (in_press[b] && st_now[b] && repeat_due(c, edge_n - press_edge[b]));
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(string tag, int obs, int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        check("count_a", int'(count_a), m_count[0]);
        check("count_b", int'(count_b), m_count[1]);
        check("limit_a", int'(limit_a), int'(m_limit[0]));
        check("limit_b", int'(limit_b), int'(m_limit[1]));
        check("held_a",  int'(held_a),  int'(m_held));
        check("held_b",  int'(held_b),  int'(m_held));
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_reset();
        else model_edge();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic press(bit up, bit down, bit clr, int low_cycles, int high_cycles);
        btn_up_n = ~up; btn_down_n = ~down; btn_clear_n = ~clr;
        repeat (low_cycles) tick();
        btn_up_n = 1'b1; btn_down_n = 1'b1; btn_clear_n = 1'b1;
        repeat (high_cycles) tick();
        $display("[TB] press up=%0d down=%0d clear=%0d low=%0d -> count_a=%0d count_b=%0d",
                 up, down, clr, low_cycles, count_a, count_b);
    endtask

    initial begin
        int remain[3];
        logic [2:0] lvl_n;

        // reset state
        do_reset();
        check("reset_count_a", int'(count_a), 0);
        check("reset_held_b", int'(held_b), 0);

        // clean press: count becomes 1 on the 8th edge (7 after the first low sample)
        btn_up_n = 1'b0;
        repeat (7) tick();
        check("clean_before", int'(count_b), 0);
        tick();
        check("clean_at_7", int'(count_b), 1);
        repeat (2) tick();
        btn_up_n = 1'b1;
        repeat (12) tick();
        check("clean_after_release", int'(count_b), 1);
        $display("[TB] clean press -> count_a=%0d count_b=%0d", count_a, count_b);

        // bounce: short lows are rejected, a 6-cycle low is accepted
        press(1, 0, 0, 3, 1);
        press(1, 0, 0, 3, 12);
        check("bounce_rejected", int'(count_b), 1);
        press(1, 0, 0, 6, 10);
        check("bounce_then_press", int'(count_b), 2);

        // wrap / saturate at the top
        do_reset();
        repeat (7) press(1, 0, 0, 6, 8);
        check("seven_ups_a", int'(count_a), 7);
        check("seven_ups_b", int'(count_b), 7);
        btn_up_n = 1'b0;
        repeat (6) tick();
        btn_up_n = 1'b1;
        repeat (2) tick();
        check("wrap_count_a", int'(count_a), 0);
        check("wrap_limit_a", int'(limit_a), 1);
        check("sat_top_b", int'(count_b), 7);
        check("sat_top_limit_b", int'(limit_b), 1);
        tick();
        check("limit_one_cycle_a", int'(limit_a), 0);
        repeat (6) tick();

        // down at zero
        do_reset();
        btn_down_n = 1'b0;
        repeat (6) tick();
        btn_down_n = 1'b1;
        repeat (2) tick();
        check("sat_zero_b", int'(count_b), 0);
        check("sat_zero_limit_b", int'(limit_b), 1);
        check("wrap_down_a", int'(count_a), 7);
        check("wrap_down_limit_a", int'(limit_a), 1);
        repeat (8) tick();

        // simultaneous events
        do_reset();
        press(1, 1, 0, 6, 8);
        check("up_down_cancel", int'(count_b), 0);
        repeat (5) press(1, 0, 0, 6, 8);
        check("five_ups", int'(count_b), 5);
        btn_up_n = 1'b0; btn_clear_n = 1'b0;
        repeat (6) tick();
        btn_up_n = 1'b1; btn_clear_n = 1'b1;
        repeat (2) tick();
        check("clear_wins_count", int'(count_a), 0);
        check("clear_no_limit", int'(limit_a), 0);
        repeat (8) tick();

        // auto-repeat: press, +1 at 8 cycles, then every 3 cycles until release
        do_reset();
        press(1, 0, 0, 26, 12);
        check("repeat_count_a", int'(count_a), 7);
        check("repeat_count_b", int'(count_b), 1);

        // reset while the button is held and debounced
        do_reset();
        btn_up_n = 1'b0;
        repeat (10) tick();
        check("midpress_before", int'(count_b), 1);
        reset = 1'b1;
        tick();
        check("midpress_reset", int'(count_b), 0);
        reset = 1'b0;
        repeat (9) tick();
        btn_up_n = 1'b1;
        repeat (12) tick();
        check("midpress_requal_a", int'(count_a), 1);
        check("midpress_requal_b", int'(count_b), 1);
        $display("[TB] reset mid-press -> count_a=%0d count_b=%0d", count_a, count_b);

        // random bouncing buttons against the model
        do_reset();
        lvl_n = 3'b111;
        for (int b = 0; b < 3; b++) remain[b] = int'($urandom_range(1, 12));
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int b = 0; b < 3; b++) begin
                remain[b] = remain[b] - 1;
                if (remain[b] == 0) begin
                    lvl_n[b] = ~lvl_n[b];
                    remain[b] = (b == 2 && lvl_n[b] == 1'b0) ? int'($urandom_range(1, 6))
                                                             : int'($urandom_range(1, 14));
                end
            end
            btn_up_n = lvl_n[0]; btn_down_n = lvl_n[1]; btn_clear_n = lvl_n[2];
            tick();
        end
        btn_up_n = 1'b1; btn_down_n = 1'b1; btn_clear_n = 1'b1;
        repeat (20) tick();
        $display("[TB] random phase -> count_a=%0d count_b=%0d", count_a, count_b);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
